// File: rtl/display_scan_controller_pkg.sv
// Shared definitions for the multiplexed 4-digit display scanner:
// FSM encoding, digit count, anode constants and nibble/anode helpers.
package display_scan_controller_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    SHOW  = 2'd2
  } state_e;

  localparam int         NUM_DIGITS = 4;
  localparam logic [3:0] AN_OFF     = 4'b1111;

  function automatic logic [3:0] nibble_of(input logic [15:0] word, input logic [1:0] idx);
    logic [3:0] n;
    case (idx)
      2'd0:    n = word[3:0];
      2'd1:    n = word[7:4];
      2'd2:    n = word[11:8];
      2'd3:    n = word[15:12];
      default: n = 4'd0;
    endcase
    return n;
  endfunction

  function automatic logic [3:0] anode_for(input logic [1:0] idx);
    logic [3:0] a;
    case (idx)
      2'd0:    a = 4'b1110;
      2'd1:    a = 4'b1101;
      2'd2:    a = 4'b1011;
      2'd3:    a = 4'b0111;
      default: a = AN_OFF;
    endcase
    return a;
  endfunction

endpackage

// File: rtl/display_scan_controller_scan_slot_timer.sv
// Per-slot prescale counter; flags the last dead-time cycle and the last
// cycle of the slot so the parent FSM can sequence BLANK/SHOW.
module scan_slot_timer #(
  parameter int PRESCALE_BITS = 17,
  parameter int BLANK_CYCLES  = 64
) (
  input  logic clock,
  input  logic reset,
  input  logic run,
  output logic slot_blank_end,
  output logic slot_end
);

  logic [PRESCALE_BITS-1:0] count_q;
  logic [PRESCALE_BITS-1:0] count_d;

  // Free-running while scanning; wraps naturally at the end of each slot.
  always_comb begin
    count_d = count_q;
    if (run) begin
      count_d = count_q + PRESCALE_BITS'(1);
    end else begin
      count_d = '0;
    end
  end

  // Counter register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign slot_blank_end = (count_q == PRESCALE_BITS'(BLANK_CYCLES - 1));
  assign slot_end       = (count_q == {PRESCALE_BITS{1'b1}});

endmodule

// File: rtl/display_scan_controller.sv
// Time-multiplexed 4-digit display scanner with a shadow/active word buffer
// that only swaps at frame boundaries (or immediately while idle).
module display_scan_controller
  import display_scan_controller_pkg::*;
#(
  parameter int PRESCALE_BITS = 17,
  parameter int BLANK_CYCLES  = 64
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  input  logic [3:0]  digit_mask,
  input  logic        load_valid,
  output logic        load_ready,
  input  logic [15:0] load_data,
  output logic [3:0]  an,
  output logic [1:0]  digit_sel,
  output logic [3:0]  nibble,
  output logic        blank,
  output logic        frame_done
);

  state_e      state_q, state_d;
  logic [1:0]  digit_sel_q, digit_sel_d;
  logic [3:0]  an_q, an_d;
  logic        blank_q, blank_d;
  logic [3:0]  nibble_q, nibble_d;
  logic        frame_done_q, frame_done_d;
  logic        load_ready_q, load_ready_d;
  logic [15:0] shadow_q, shadow_d;
  logic [15:0] active_q, active_d;
  logic        pending_q, pending_d;

  logic run_s;
  logic slot_blank_end_s;
  logic slot_end_s;
  logic frame_boundary_s;
  logic capture_s;
  logic commit_s;

  assign run_s = (state_q != IDLE) && enable;

  scan_slot_timer #(
    .PRESCALE_BITS (PRESCALE_BITS),
    .BLANK_CYCLES  (BLANK_CYCLES)
  ) u_timer (
    .clock          (clock),
    .reset          (reset),
    .run            (run_s),
    .slot_blank_end (slot_blank_end_s),
    .slot_end       (slot_end_s)
  );

  assign frame_boundary_s = (state_q == SHOW) && enable && slot_end_s &&
                            (digit_sel_q == 2'(NUM_DIGITS - 1));
  assign capture_s        = load_valid && load_ready_q;
  // pending_q (not capture_s) gates the commit, so a word captured on the
  // boundary edge waits for the following frame.
  assign commit_s         = pending_q && (frame_boundary_s || (state_q == IDLE));

  // Next-state and digit sequencing.
  always_comb begin
    state_d     = state_q;
    digit_sel_d = digit_sel_q;
    case (state_q)
      IDLE: begin
        digit_sel_d = 2'd0;
        if (enable) begin
          state_d = BLANK;
        end else begin
          state_d = IDLE;
        end
      end
      BLANK: begin
        if (!enable) begin
          state_d     = IDLE;
          digit_sel_d = 2'd0;
        end else if (slot_blank_end_s) begin
          state_d = SHOW;
        end else begin
          state_d = BLANK;
        end
      end
      SHOW: begin
        if (!enable) begin
          state_d     = IDLE;
          digit_sel_d = 2'd0;
        end else if (slot_end_s) begin
          state_d     = BLANK;
          digit_sel_d = digit_sel_q + 2'd1;
        end else begin
          state_d = SHOW;
        end
      end
      default: begin
        state_d     = IDLE;
        digit_sel_d = 2'd0;
      end
    endcase
  end

  // Load handshake and buffer swap.
  always_comb begin
    shadow_d     = shadow_q;
    active_d     = active_q;
    pending_d    = pending_q;
    load_ready_d = load_ready_q;
    frame_done_d = 1'b0;
    if (commit_s) begin
      active_d     = shadow_q;
      pending_d    = 1'b0;
      load_ready_d = 1'b1;
      frame_done_d = 1'b1;
    end else if (capture_s) begin
      shadow_d     = load_data;
      pending_d    = 1'b1;
      load_ready_d = 1'b0;
    end else begin
      frame_done_d = 1'b0;
    end
  end

  // Display outputs, derived from the upcoming state so they stay registered.
  always_comb begin
    an_d    = AN_OFF;
    blank_d = 1'b1;
    if ((state_d == SHOW) && digit_mask[digit_sel_d]) begin
      an_d    = anode_for(digit_sel_d);
      blank_d = 1'b0;
    end else begin
      an_d    = AN_OFF;
      blank_d = 1'b1;
    end
    nibble_d = nibble_of(active_d, digit_sel_d);
  end

  // FSM state register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      digit_sel_q  <= 2'd0;
      an_q         <= AN_OFF;
      blank_q      <= 1'b1;
      nibble_q     <= 4'd0;
      frame_done_q <= 1'b0;
      load_ready_q <= 1'b1;
      shadow_q     <= 16'd0;
      active_q     <= 16'd0;
      pending_q    <= 1'b0;
    end else begin
      digit_sel_q  <= digit_sel_d;
      an_q         <= an_d;
      blank_q      <= blank_d;
      nibble_q     <= nibble_d;
      frame_done_q <= frame_done_d;
      load_ready_q <= load_ready_d;
      shadow_q     <= shadow_d;
      active_q     <= active_d;
      pending_q    <= pending_d;
    end
  end

  assign an         = an_q;
  assign digit_sel  = digit_sel_q;
  assign nibble     = nibble_q;
  assign blank      = blank_q;
  assign frame_done = frame_done_q;
  assign load_ready = load_ready_q;

endmodule

// File: tb/tb_display_scan_controller.sv
// Directed bench for display_scan_controller with 16-cycle slots, 2 dead cycles.
module tb_display_scan_controller;

  logic        clock;
  logic        reset;
  logic        enable;
  logic [3:0]  digit_mask;
  logic        load_valid;
  logic        load_ready;
  logic [15:0] load_data;
  logic [3:0]  an;
  logic [1:0]  digit_sel;
  logic [3:0]  nibble;
  logic        blank;
  logic        frame_done;

  int errors = 0;
  int checks = 0;

  display_scan_controller #(.PRESCALE_BITS(4), .BLANK_CYCLES(2)) dut (
    .clock      (clock),
    .reset      (reset),
    .enable     (enable),
    .digit_mask (digit_mask),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_data  (load_data),
    .an         (an),
    .digit_sel  (digit_sel),
    .nibble     (nibble),
    .blank      (blank),
    .frame_done (frame_done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [3:0] exp_an(input int ofs, input int slot, input logic [3:0] mask);
    if (ofs < 2 || !mask[slot]) return 4'b1111;
    return ~(4'b0001 << slot);
  endfunction

  function automatic logic [3:0] word_nib(input logic [15:0] w, input int i);
    return w[i*4 +: 4];
  endfunction

  task automatic test_reset();
    reset = 1'b1; enable = 1'b0; digit_mask = 4'hF; load_valid = 1'b0; load_data = 16'h0000;
    @(negedge clock);
    checks++; if (an !== 4'b1111) begin errors++; $display("FAIL reset_an: got %b expected 1111", an); end
    checks++; if (blank !== 1'b1) begin errors++; $display("FAIL reset_blank: got %b expected 1", blank); end
    checks++; if (digit_sel !== 2'd0) begin errors++; $display("FAIL reset_digit_sel: got %0d expected 0", digit_sel); end
    checks++; if (nibble !== 4'h0) begin errors++; $display("FAIL reset_nibble: got %h expected 0", nibble); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done: got %b expected 0", frame_done); end
    checks++; if (load_ready !== 1'b1) begin errors++; $display("FAIL reset_load_ready: got %b expected 1", load_ready); end
    reset = 1'b0;
    @(negedge clock);
    checks++; if (an !== 4'b1111) begin errors++; $display("FAIL idle_an: got %b expected 1111", an); end
  endtask

  task automatic test_load_idle();
    load_valid = 1'b1; load_data = 16'h4321;
    @(negedge clock);
    load_valid = 1'b0;
    checks++; if (load_ready !== 1'b0) begin errors++; $display("FAIL idle_capture_ready: got %b expected 0", load_ready); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL idle_capture_done: got %b expected 0", frame_done); end
    @(negedge clock);
    checks++; if (frame_done !== 1'b1) begin errors++; $display("FAIL idle_commit_done: got %b expected 1", frame_done); end
    checks++; if (load_ready !== 1'b1) begin errors++; $display("FAIL idle_commit_ready: got %b expected 1", load_ready); end
    checks++; if (nibble !== 4'h1) begin errors++; $display("FAIL idle_commit_nibble: got %h expected 1", nibble); end
    @(negedge clock);
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL idle_done_pulse: got %b expected 0", frame_done); end
  endtask

  task automatic test_scan();
    int slot, ofs;
    int low[4];
    for (int i = 0; i < 4; i++) low[i] = 0;
    enable = 1'b1; digit_mask = 4'hF;
    for (int c = 0; c < 64; c++) begin
      @(negedge clock);
      slot = c / 16; ofs = c % 16;
      checks++; if (an !== exp_an(ofs, slot, 4'hF)) begin errors++; $display("FAIL scan_an c=%0d: got %b expected %b", c, an, exp_an(ofs, slot, 4'hF)); end
      checks++; if (digit_sel !== 2'(slot)) begin errors++; $display("FAIL scan_digit_sel c=%0d: got %0d expected %0d", c, digit_sel, slot); end
      checks++; if (nibble !== word_nib(16'h4321, slot)) begin errors++; $display("FAIL scan_nibble c=%0d: got %h expected %h", c, nibble, word_nib(16'h4321, slot)); end
      if (an[slot] == 1'b0) low[slot]++;
    end
    for (int i = 0; i < 4; i++) begin
      checks++; if (low[i] != 14) begin errors++; $display("FAIL scan_low_count digit=%0d: got %0d expected 14", i, low[i]); end
    end
  endtask

  task automatic test_mask();
    int slot, ofs;
    digit_mask = 4'b0101;
    for (int c = 0; c < 64; c++) begin
      @(negedge clock);
      slot = c / 16; ofs = c % 16;
      checks++; if (an !== exp_an(ofs, slot, 4'b0101)) begin errors++; $display("FAIL mask_an c=%0d: got %b expected %b", c, an, exp_an(ofs, slot, 4'b0101)); end
      checks++; if (blank !== (exp_an(ofs, slot, 4'b0101) == 4'b1111)) begin errors++; $display("FAIL mask_blank c=%0d: got %b", c, blank); end
    end
  endtask

  task automatic test_midframe_load();
    logic [15:0] w;
    digit_mask = 4'hF;
    for (int k = 0; k <= 128; k++) begin
      @(negedge clock);
      w = (k < 64) ? 16'h4321 : 16'hABCD;
      checks++; if (nibble !== word_nib(w, (k % 64) / 16)) begin errors++; $display("FAIL midload_nibble k=%0d: got %h expected %h", k, nibble, word_nib(w, (k % 64) / 16)); end
      checks++; if (frame_done !== (k == 64)) begin errors++; $display("FAIL midload_done k=%0d: got %b expected %b", k, frame_done, (k == 64)); end
      checks++; if (load_ready !== (k <= 20 || k >= 64)) begin errors++; $display("FAIL midload_ready k=%0d: got %b expected %b", k, load_ready, (k <= 20 || k >= 64)); end
      if (k == 20) begin load_valid = 1'b1; load_data = 16'hABCD; end
      if (k == 21) load_data = 16'hBEEF;
      if (k == 22) load_valid = 1'b0;
    end
  endtask

  task automatic test_boundary_capture();
    for (int k = 1; k <= 128; k++) begin
      @(negedge clock);
      checks++; if (frame_done !== (k == 128)) begin errors++; $display("FAIL bnd_done k=%0d: got %b expected %b", k, frame_done, (k == 128)); end
      checks++; if (load_ready !== !(k >= 64 && k < 128)) begin errors++; $display("FAIL bnd_ready k=%0d: got %b expected %b", k, load_ready, !(k >= 64 && k < 128)); end
      if (k == 64) begin
        load_valid = 1'b0;
        checks++; if (nibble !== 4'hD) begin errors++; $display("FAIL bnd_old_nibble: got %h expected d", nibble); end
      end
      if (k == 128) begin
        checks++; if (nibble !== 4'hC) begin errors++; $display("FAIL bnd_new_nibble: got %h expected c", nibble); end
      end
      if (k == 63) begin load_valid = 1'b1; load_data = 16'h5A3C; end
    end
  endtask

  task automatic test_disable();
    repeat (20) @(negedge clock);
    checks++; if (an !== 4'b1101) begin errors++; $display("FAIL dis_pre_an: got %b expected 1101", an); end
    checks++; if (digit_sel !== 2'd1) begin errors++; $display("FAIL dis_pre_sel: got %0d expected 1", digit_sel); end
    checks++; if (nibble !== 4'h3) begin errors++; $display("FAIL dis_pre_nibble: got %h expected 3", nibble); end
    enable = 1'b0;
    @(negedge clock);
    checks++; if (an !== 4'b1111) begin errors++; $display("FAIL dis_an: got %b expected 1111", an); end
    checks++; if (digit_sel !== 2'd0) begin errors++; $display("FAIL dis_sel: got %0d expected 0", digit_sel); end
    checks++; if (blank !== 1'b1) begin errors++; $display("FAIL dis_blank: got %b expected 1", blank); end
    checks++; if (nibble !== 4'hC) begin errors++; $display("FAIL dis_nibble: got %h expected c", nibble); end
    @(negedge clock);
    checks++; if (an !== 4'b1111) begin errors++; $display("FAIL dis_hold_an: got %b expected 1111", an); end
    enable = 1'b1;
    @(negedge clock);
    checks++; if (an !== 4'b1111) begin errors++; $display("FAIL restart_blank0_an: got %b expected 1111", an); end
    checks++; if (digit_sel !== 2'd0) begin errors++; $display("FAIL restart_sel: got %0d expected 0", digit_sel); end
    @(negedge clock);
    checks++; if (an !== 4'b1111) begin errors++; $display("FAIL restart_blank1_an: got %b expected 1111", an); end
    @(negedge clock);
    checks++; if (an !== 4'b1110) begin errors++; $display("FAIL restart_show_an: got %b expected 1110", an); end
    checks++; if (nibble !== 4'hC) begin errors++; $display("FAIL restart_nibble: got %h expected c", nibble); end
  endtask

  task automatic test_async_reset();
    load_valid = 1'b1; load_data = 16'h9999;
    @(negedge clock);
    load_valid = 1'b0;
    checks++; if (load_ready !== 1'b0) begin errors++; $display("FAIL ar_pending_ready: got %b expected 0", load_ready); end
    repeat (2) @(negedge clock);
    checks++; if (an !== 4'b1110) begin errors++; $display("FAIL ar_pre_an: got %b expected 1110", an); end
    #2 reset = 1'b1;
    #1;
    checks++; if (an !== 4'b1111) begin errors++; $display("FAIL ar_an: got %b expected 1111", an); end
    checks++; if (blank !== 1'b1) begin errors++; $display("FAIL ar_blank: got %b expected 1", blank); end
    checks++; if (nibble !== 4'h0) begin errors++; $display("FAIL ar_nibble: got %h expected 0", nibble); end
    checks++; if (load_ready !== 1'b1) begin errors++; $display("FAIL ar_ready: got %b expected 1", load_ready); end
    checks++; if (digit_sel !== 2'd0) begin errors++; $display("FAIL ar_sel: got %0d expected 0", digit_sel); end
    enable = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL ar_lost_done i=%0d: got %b expected 0", i, frame_done); end
      checks++; if (nibble !== 4'h0) begin errors++; $display("FAIL ar_lost_nibble i=%0d: got %h expected 0", i, nibble); end
    end
    enable = 1'b1;
    @(negedge clock);
    checks++; if (an !== 4'b1111) begin errors++; $display("FAIL ar_resume_blank_an: got %b expected 1111", an); end
    repeat (2) @(negedge clock);
    checks++; if (an !== 4'b1110) begin errors++; $display("FAIL ar_resume_show_an: got %b expected 1110", an); end
    checks++; if (nibble !== 4'h0) begin errors++; $display("FAIL ar_resume_nibble: got %h expected 0", nibble); end
  endtask

  initial begin
    test_reset();
    test_load_idle();
    test_scan();
    test_mask();
    test_midframe_load();
    test_boundary_capture();
    test_disable();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/display_scan_controller.md
DISPLAY_SCAN_CONTROLLER -- requirements
Module: display_scan_controller

Interface
REQ-001 Parameter PRESCALE_BITS, default 17: each digit slot lasts 2^PRESCALE_BITS clock cycles.
REQ-002 Parameter BLANK_CYCLES, default 64: the first BLANK_CYCLES cycles of every slot are dead time with all anodes off; legal range 1 to 2^PRESCALE_BITS-2.
REQ-003 Port clock, input, 1: single system clock; all state changes on its rising edge.
REQ-004 Port reset, input, 1: asynchronous, active-high reset.
REQ-005 Port enable, input, 1: 1 = scanning runs; 0 = display off.
REQ-006 Port digit_mask, input, 4: bit i = 1 shows digit i; 0 keeps digit i dark during its slot.
REQ-007 Port load_valid, input, 1: a new display word is offered.
REQ-008 Port load_ready, output, 1: the shadow buffer is empty and can accept a word.
REQ-009 Port load_data, input, 16: four nibbles; digit i in bits [4i+3:4i].
REQ-010 Port an, output, 4: anodes, active-low, one-hot-low or all-high.
REQ-011 Port digit_sel, output, 2: index of the current slot's digit.
REQ-012 Port nibble, output, 4: active-buffer nibble for digit_sel, routed to the decoder.
REQ-013 Port blank, output, 1: 1 = the decoder drives all segments off.
REQ-014 Port frame_done, output, 1: one-cycle pulse when the shadow word commits to the active buffer.

Function
REQ-015 The FSM states SHALL be IDLE, BLANK and SHOW; all outputs SHALL be registered.
REQ-016 In IDLE with enable=1, the next edge SHALL enter BLANK with digit_sel=0 and slot counter=0.
REQ-017 The slot counter SHALL increment every cycle in BLANK/SHOW; BLANK->SHOW when counter = BLANK_CYCLES-1.
REQ-018 At counter = 2^PRESCALE_BITS-1 in SHOW, the counter SHALL wrap to 0, digit_sel SHALL advance modulo 4 (3->0), and the state SHALL go to BLANK.
REQ-019 In BLANK: an=4'b1111 and blank=1. In SHOW: an[digit_sel]=0 and blank=0 if digit_mask[digit_sel]=1, otherwise an=4'b1111 and blank=1.
REQ-020 digit_mask SHALL be sampled every cycle; a change takes effect on the next edge.
REQ-021 enable=0 in BLANK/SHOW SHALL force IDLE on the next edge (an=4'b1111, blank=1, digit_sel=0, counter=0); the active buffer is retained.
REQ-022 nibble SHALL equal active_buffer[digit_sel] in every state.
REQ-023 The handshake SHALL capture load_data into the shadow on a cycle where load_valid&&load_ready; load_ready SHALL then be 0 from the next cycle.
REQ-024 A pending shadow word SHALL commit at the frame boundary (the REQ-018 wrap from digit_sel=3), or on the first edge after capture while in IDLE; frame_done=1 and load_ready=1 in the same registered update.
REQ-025 A capture on the same cycle as a frame boundary SHALL NOT commit at that boundary; it commits at the next one.
REQ-026 load_valid while load_ready=0 SHALL be ignored and SHALL NOT modify the shadow.
REQ-027 The active buffer SHALL never change mid-frame, so all four digits of one frame come from one word.

Reset
REQ-028 Asserting reset SHALL immediately force: state IDLE, counter 0, digit_sel 0, an 4'b1111, blank 1, nibble 0, frame_done 0, load_ready 1, shadow 0, active buffer 0, pending 0.
REQ-029 Reset mid-slot or mid-handshake SHALL discard any pending word; operation resumes per REQ-016 after release.

Structure
REQ-030 A shared package SHALL hold the FSM state encoding, NUM_DIGITS=4 and the anode-off constant 4'b1111.
REQ-031 One sub-module, scan_slot_timer, SHALL contain the prescale counter and emit slot_blank_end and slot_end strobes; the FSM, handshake and buffers stay in the parent.

Verification (PRESCALE_BITS=4, BLANK_CYCLES=2: slot = 16 cycles, frame = 64 cycles)
REQ-032 Reset, enable=1, mask=4'hF, load 16'h4321 while idle -> frame_done 1 cycle later; an cycles 1110,1101,1011,0111, each low for 14 of 16 cycles; nibble 1,2,3,4.
REQ-033 mask=4'b0101 -> an low only in the digit-0 and digit-2 slots; blank=1 throughout the digit-1 and digit-3 slots.
REQ-034 Load 16'hABCD mid-frame -> load_ready=0 until the digit-3->0 wrap, then frame_done pulse; 16'hBEEF offered while load_ready=0 is not captured.
REQ-035 Capture on the exact boundary cycle -> no commit there; commit and frame_done 64 cycles later.
REQ-036 enable=0 mid-SHOW -> next cycle an=4'b1111, digit_sel=0; enable=1 restarts at digit 0 with BLANK.
REQ-037 Reset asserted mid-SHOW between clock edges -> an=4'b1111 immediately, before the next edge; pending word lost, nibble=0.
